// File: rtl/ahb_slave_mem.sv
// AHB-Lite-style P-bus slave RAM: byte/half/word/dword access, write data right-aligned in PWDATA.
// Read data 1+WAIT_STATES cycles after capture; PREADY low for wait states, 2-cycle ERROR response.
module ahb_slave_mem #(
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       DATA_W      = 32,
   parameter int unsigned       DEPTH       = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int unsigned       WAIT_STATES = 0,
   parameter bit                ERR_EN      = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic              PWRITE,
   input  logic [1:0]        PSIZE,
   input  logic [1:0]        PTRANS,
   input  logic [2:0]        PBURST,
   input  logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY,
   output logic              PRESP
);
   localparam int unsigned     NBYTES    = DATA_W / 8;
   localparam int unsigned     LANE_W    = $clog2(NBYTES);
   localparam int unsigned     IDX_W     = $clog2(DEPTH);
   localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(DEPTH * NBYTES);
   localparam logic [3:0]      WS_LOAD   = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                wr_q, bad_q;
   logic [IDX_W-1:0]    idx_q;
   logic [LANE_W-1:0]   lane_q;
   logic [NBYTES-1:0]   be_q;
   logic [DATA_W-1:0]   prdata_q;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic [ADDR_W-1:0]   off;
   logic [7:0]          sz_mask;
   logic                size_bad, misalign, range_bad, bad;
   logic [NBYTES-1:0]   be;
   logic                capture, rd_phase, wr_commit;
   logic [DATA_W-1:0]   wdata_sh;
   logic                unused_ok;

   assign unused_ok = ^{PBURST, PTRANS[0]};

   always_comb begin
      off       = PADDR - BASE_ADDR;
      sz_mask   = 8'h00;
      size_bad  = 1'b0;
      misalign  = 1'b0;
      case (PSIZE)
         2'd0: sz_mask = 8'h01;
         2'd1: begin sz_mask = 8'h03; misalign = PADDR[0];     end
         2'd2: begin sz_mask = 8'h0f; misalign = |PADDR[1:0]; end
         default: begin
            sz_mask  = 8'hff;
            misalign = |PADDR[2:0];
            size_bad = (DATA_W != 64);
         end
      endcase
      range_bad = ({1'b0, off} >= MEM_BYTES);
      bad       = size_bad | misalign | range_bad;
      be        = NBYTES'(sz_mask << off[LANE_W-1:0]);
   end

   assign PREADY  = (state_q == ST_IDLE) | (state_q == ST_DATA) | (state_q == ST_ERR2);
   assign PRESP   = (state_q == ST_ERR1) | (state_q == ST_ERR2);
   assign capture = PREADY & PTRANS[1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_WAIT: begin
            if (cnt_q == 4'd0) state_d = ST_DATA;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_ERR1: state_d = ST_ERR2;
         default: begin
            state_d = ST_IDLE;
            if (capture) begin
               if (ERR_EN && bad) begin
                  state_d = ST_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = WS_LOAD;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
      endcase
   end

   // Bad transfers only reach DATA with ERR_EN=0: reads return zero, writes are dropped.
   assign rd_phase  = (state_q == ST_DATA) & ~wr_q;
   assign wr_commit = (state_q == ST_DATA) & wr_q & ~bad_q;
   assign PRDATA    = rd_phase ? (bad_q ? '0 : mem[idx_q]) : prdata_q;
   assign wdata_sh  = PWDATA << {lane_q, 3'b000};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         wr_q     <= 1'b0;
         bad_q    <= 1'b0;
         idx_q    <= '0;
         lane_q   <= '0;
         be_q     <= '0;
         prdata_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         prdata_q <= PRDATA;
         if (capture) begin
            wr_q   <= PWRITE;
            bad_q  <= bad;
            idx_q  <= off[LANE_W +: IDX_W];
            lane_q <= off[LANE_W-1:0];
            be_q   <= be;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_commit) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: three instances (zero-wait, 3 wait states at a non-zero base, ERR_EN=0)
// driven from per-instance transfer tables by a pipelined master with an in-order expectation queue.
module tb_ahb_slave_mem;
   localparam logic [1:0] ID = 2'b00, BZ = 2'b01, NS = 2'b10, SQ = 2'b11;
   localparam logic [1:0] SB = 2'd0, SH = 2'd1, SW = 2'd2, SD = 2'd3;

   logic        clk;
   logic        rst_n  [3];
   logic [31:0] paddr  [3];
   logic        pwrite [3];
   logic [1:0]  psize  [3];
   logic [1:0]  ptrans [3];
   logic [2:0]  pburst [3];
   logic [31:0] pwdata [3];
   logic [31:0] prdata [3];
   logic        pready [3];
   logic        presp  [3];

   typedef struct {
      logic [1:0]  trans;
      logic        wr;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
      logic        err;
      logic        ckr;
      logic [31:0] rdata;
   } op_t;

   typedef struct {
      int          idx;
      logic        err;
      logic        ckr;
      logic [31:0] rdata;
      int          waits;
   } exp_t;

   op_t  ops[$];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   busy;

   ahb_slave_mem #(.DEPTH(64), .BASE_ADDR(32'h0), .WAIT_STATES(0), .ERR_EN(1'b1)) u_d0 (
      .clk(clk), .rst_n(rst_n[0]), .PADDR(paddr[0]), .PWRITE(pwrite[0]), .PSIZE(psize[0]),
      .PTRANS(ptrans[0]), .PBURST(pburst[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]),
      .PREADY(pready[0]), .PRESP(presp[0]));

   ahb_slave_mem #(.DEPTH(64), .BASE_ADDR(32'h1000), .WAIT_STATES(3), .ERR_EN(1'b1)) u_d1 (
      .clk(clk), .rst_n(rst_n[1]), .PADDR(paddr[1]), .PWRITE(pwrite[1]), .PSIZE(psize[1]),
      .PTRANS(ptrans[1]), .PBURST(pburst[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]),
      .PREADY(pready[1]), .PRESP(presp[1]));

   ahb_slave_mem #(.DEPTH(64), .BASE_ADDR(32'h0), .WAIT_STATES(0), .ERR_EN(1'b0)) u_d2 (
      .clk(clk), .rst_n(rst_n[2]), .PADDR(paddr[2]), .PWRITE(pwrite[2]), .PSIZE(psize[2]),
      .PTRANS(ptrans[2]), .PBURST(pburst[2]), .PWDATA(pwdata[2]), .PRDATA(prdata[2]),
      .PREADY(pready[2]), .PRESP(presp[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic [1:0] t, input logic w, input logic [31:0] a,
                      input logic [1:0] s, input logic [31:0] wd, input logic e,
                      input logic c, input logic [31:0] rd);
      op_t o;
      o.trans = t; o.wr = w; o.addr = a; o.size = s; o.wdata = wd;
      o.err = e; o.ckr = c; o.rdata = rd;
      ops.push_back(o);
   endtask

   task automatic drive(input int d, input int i, input logic [31:0] wd);
      pwdata[d] = wd;
      if (i < ops.size()) begin
         ptrans[d] = ops[i].trans;
         pwrite[d] = ops[i].wr;
         paddr[d]  = ops[i].addr;
         psize[d]  = ops[i].size;
      end else begin
         ptrans[d] = ID;
      end
   endtask

   // Pipelined master: the address phase of op i overlaps the data phase of the previous transfer.
   task automatic run_ops(input int d, input int ws, output int busy_cyc);
      int          i, guard, low;
      bit          dp;
      exp_t        cur;
      logic [31:0] wd;
      i = 0; guard = 0; low = 0; dp = 0; busy_cyc = 0; wd = '0;
      sb.delete();
      @(posedge clk); #1;
      drive(d, 0, wd);
      while (1) begin
         @(negedge clk);
         if (dp) busy_cyc++;
         if (pready[d]) begin
            if (dp) begin
               cur = sb.pop_front();
               dp  = 0;
               chk($sformatf("d%0d op%0d resp", d, cur.idx), 32'(presp[d]), 32'(cur.err));
               chk($sformatf("d%0d op%0d waits", d, cur.idx), 32'(low), 32'(cur.waits));
               if (cur.ckr)
                  chk($sformatf("d%0d op%0d rdata", d, cur.idx), prdata[d], cur.rdata);
            end else begin
               chk($sformatf("d%0d idle resp", d), 32'(presp[d]), 32'd0);
            end
            if (i < ops.size()) begin
               if (ops[i].trans[1]) begin
                  cur.idx   = i;
                  cur.err   = ops[i].err;
                  cur.ckr   = ops[i].ckr;
                  cur.rdata = ops[i].rdata;
                  cur.waits = ops[i].err ? 1 : ws;
                  sb.push_back(cur);
                  dp  = 1;
                  low = 0;
                  wd  = ops[i].wdata;
               end
               i++;
            end
         end else if (dp) begin
            low++;
            chk($sformatf("d%0d op%0d wait resp", d, sb[0].idx), 32'(presp[d]), 32'(sb[0].err));
         end else begin
            chk($sformatf("d%0d stray wait", d), 32'(pready[d]), 32'd1);
         end
         if (i >= ops.size() && !dp) break;
         guard++;
         if (guard > 400) begin
            n_cmp++;
            n_bad++;
            $display("FAIL d%0d timeout: got %0d pending, want 0", d, sb.size());
            break;
         end
         @(posedge clk); #1;
         drive(d, i, wd);
      end
      ptrans[d] = ID;
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst_n[d] = 1'b0; ptrans[d] = ID; paddr[d] = '0; pwrite[d] = 1'b0;
         psize[d] = SW; pburst[d] = 3'b001; pwdata[d] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("d%0d rst ready", d), 32'(pready[d]), 32'd1);
         chk($sformatf("d%0d rst resp", d), 32'(presp[d]), 32'd0);
         chk($sformatf("d%0d rst rdata", d), prdata[d], 32'd0);
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

      // Zero-wait instance: RAW, lane writes, errors, BUSY/IDLE inside a burst.
      ops.delete();
      add(NS, 1, 32'h10,  SW, 32'hDEADBEEF, 0, 0, 32'h0);
      add(NS, 0, 32'h10,  SW, 32'h0,        0, 1, 32'hDEADBEEF);
      add(NS, 1, 32'h10,  SW, 32'h12345678, 0, 0, 32'h0);
      add(NS, 1, 32'h13,  SB, 32'h000000AA, 0, 0, 32'h0);
      add(NS, 0, 32'h10,  SW, 32'h0,        0, 1, 32'hAA345678);
      add(NS, 1, 32'h18,  SW, 32'h11223344, 0, 0, 32'h0);
      add(NS, 1, 32'h1A,  SH, 32'h0000BEEF, 0, 0, 32'h0);
      add(NS, 1, 32'h19,  SB, 32'h00000055, 0, 0, 32'h0);
      add(NS, 0, 32'h18,  SH, 32'h0,        0, 1, 32'hBEEF5544);
      add(NS, 1, 32'h14,  SW, 32'hCAFEF00D, 0, 0, 32'h0);
      add(NS, 0, 32'h100, SW, 32'h0,        1, 1, 32'hBEEF5544);
      add(NS, 0, 32'h01,  SH, 32'h0,        1, 1, 32'hBEEF5544);
      add(NS, 1, 32'h12,  SW, 32'hFFFFFFFF, 1, 0, 32'h0);
      add(NS, 0, 32'h18,  SD, 32'h0,        1, 1, 32'hBEEF5544);
      add(NS, 0, 32'h10,  SW, 32'h0,        0, 1, 32'hAA345678);
      add(NS, 0, 32'h10,  SW, 32'h0,        0, 1, 32'hAA345678);
      add(BZ, 1, 32'h14,  SW, 32'h0,        0, 0, 32'h0);
      add(SQ, 0, 32'h14,  SW, 32'h0,        0, 1, 32'hCAFEF00D);
      add(ID, 1, 32'h18,  SW, 32'h0,        0, 0, 32'h0);
      add(SQ, 0, 32'h18,  SW, 32'h0,        0, 1, 32'hBEEF5544);
      add(NS, 0, 32'h14,  SW, 32'h0,        0, 1, 32'hCAFEF00D);
      run_ops(0, 0, busy);

      // Three-wait-state instance at base 0x1000.
      ops.delete();
      add(NS, 1, 32'h1000, SW, 32'h01020304, 0, 0, 32'h0);
      add(SQ, 1, 32'h1004, SW, 32'h05060708, 0, 0, 32'h0);
      add(SQ, 1, 32'h1008, SW, 32'h090A0B0C, 0, 0, 32'h0);
      add(SQ, 1, 32'h100C, SW, 32'h0D0E0F10, 0, 0, 32'h0);
      add(NS, 1, 32'h1010, SW, 32'h11111111, 0, 0, 32'h0);
      add(NS, 0, 32'h1100, SW, 32'h0,        1, 1, 32'h0);
      add(NS, 0, 32'h0FFC, SW, 32'h0,        1, 1, 32'h0);
      run_ops(1, 3, busy);

      ops.delete();
      add(NS, 0, 32'h1000, SW, 32'h0, 0, 1, 32'h01020304);
      add(SQ, 0, 32'h1004, SW, 32'h0, 0, 1, 32'h05060708);
      add(SQ, 0, 32'h1008, SW, 32'h0, 0, 1, 32'h090A0B0C);
      add(SQ, 0, 32'h100C, SW, 32'h0, 0, 1, 32'h0D0E0F10);
      run_ops(1, 3, busy);
      chk("d1 burst cycles", 32'(busy), 32'd16);

      // Reset while a write sits in its wait states: the write must not land.
      @(posedge clk); #1;
      ptrans[1] = NS; pwrite[1] = 1'b1; paddr[1] = 32'h1010; psize[1] = SW;
      @(negedge clk);
      chk("d1 rmw addr ready", 32'(pready[1]), 32'd1);
      @(posedge clk); #1;
      ptrans[1] = ID; pwdata[1] = 32'h77777777;
      @(negedge clk);
      chk("d1 rmw in wait", 32'(pready[1]), 32'd0);
      rst_n[1] = 1'b0;
      #1;
      chk("d1 rmw rst ready", 32'(pready[1]), 32'd1);
      chk("d1 rmw rst resp", 32'(presp[1]), 32'd0);
      chk("d1 rmw rst rdata", prdata[1], 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n[1] = 1'b1;
      @(negedge clk);
      chk("d1 post-rst idle", 32'(pready[1]), 32'd1);

      ops.delete();
      add(NS, 0, 32'h1010, SW, 32'h0, 0, 1, 32'h11111111);
      add(NS, 0, 32'h1100, SW, 32'h0, 1, 1, 32'h11111111);
      run_ops(1, 3, busy);

      // ERR_EN=0 instance: bad transfers complete OKAY, writes dropped, reads zero.
      ops.delete();
      add(NS, 1, 32'h20,  SW, 32'h5A5A5A5A, 0, 0, 32'h0);
      add(NS, 0, 32'h20,  SW, 32'h0,        0, 1, 32'h5A5A5A5A);
      add(NS, 0, 32'h100, SW, 32'h0,        0, 1, 32'h0);
      add(NS, 1, 32'h22,  SW, 32'hFFFFFFFF, 0, 0, 32'h0);
      add(NS, 1, 32'h100, SW, 32'hFFFFFFFF, 0, 0, 32'h0);
      add(NS, 0, 32'h20,  SW, 32'h0,        0, 1, 32'h5A5A5A5A);
      add(NS, 0, 32'h21,  SH, 32'h0,        0, 1, 32'h0);
      run_ops(2, 0, busy);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
